// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes the immediate format, sign-extends to XLEN,
// adds it to the PC, and hands the result out through an output register backed by a skid slot.
module imm_gen_pipe #(
    parameter int XLEN         = 32,
    parameter int ENABLE_ZICSR = 1,
    parameter int ENABLE_RV64I = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instruction_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            imm_valid_o,
    input  logic            imm_ready_i,
    output logic [XLEN-1:0] imm_ext_o,
    output logic [2:0]      imm_type_o,
    output logic [XLEN-1:0] target_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;

    // OP-IMM-32 only exists on a 64-bit datapath.
    localparam bit RV64_OPS = (ENABLE_RV64I != 0) && (XLEN == 64);
    localparam bit ZICSR_ON = (ENABLE_ZICSR != 0);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic [XLEN-1:0] target;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } beat_t;

    logic [2:0]      d_type;
    logic [XLEN-1:0] d_imm;
    beat_t           in_beat;
    beat_t           or_q;
    beat_t           sk_q;
    logic            or_valid;
    logic            sk_valid;
    logic            accept;
    logic            or_free;

    always_comb begin
        d_type = T_NONE;
        if (instruction_i[1:0] == 2'b11) begin
            case (instruction_i[6:2])
                5'b00000, 5'b00100, 5'b11001, 5'b00011: d_type = T_I;
                5'b00110: d_type = RV64_OPS ? T_I : T_NONE;
                5'b01000: d_type = T_S;
                5'b11000: d_type = T_B;
                5'b01101, 5'b00101: d_type = T_U;
                5'b11011: d_type = T_J;
                5'b11100: d_type = (ZICSR_ON && instruction_i[14]) ? T_Z : T_I;
                default:  d_type = T_NONE;
            endcase
        end
    end

    always_comb begin
        d_imm = '0;
        case (d_type)
            T_I: d_imm = XLEN'($signed(instruction_i[31:20]));
            T_S: d_imm = XLEN'($signed({instruction_i[31:25], instruction_i[11:7]}));
            T_B: d_imm = XLEN'($signed({instruction_i[31], instruction_i[7],
                                        instruction_i[30:25], instruction_i[11:8], 1'b0}));
            T_U: d_imm = XLEN'($signed({instruction_i[31:12], 12'b0}));
            T_J: d_imm = XLEN'($signed({instruction_i[31], instruction_i[19:12],
                                        instruction_i[20], instruction_i[30:21], 1'b0}));
            T_Z: d_imm = XLEN'(instruction_i[19:15]);
            default: d_imm = '0;
        endcase
    end

    always_comb begin
        in_beat        = '0;
        in_beat.imm    = d_imm;
        in_beat.typ    = d_type;
        in_beat.target = pc_i + d_imm;
        in_beat.instr  = instruction_i;
        in_beat.pc     = pc_i;
    end

    // Handshake: a beat moves on a cycle where valid && ready; valid never waits on ready,
    // and a stalled output (valid && !ready) holds every output port stable.
    assign instr_ready_o = !sk_valid;
    assign accept        = instr_valid_i && instr_ready_o;
    assign or_free       = !or_valid || imm_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            or_valid <= 1'b0;
            or_q     <= '0;
            sk_valid <= 1'b0;
            sk_q     <= '0;
        end else if (flush_i) begin
            or_valid <= 1'b0;
            or_q     <= '0;
            sk_valid <= 1'b0;
        end else if (or_free) begin
            // SK, when full, is older than any input and keeps instr_ready_o low.
            if (sk_valid) begin
                or_valid <= 1'b1;
                or_q     <= sk_q;
                sk_valid <= 1'b0;
            end else begin
                or_valid <= accept;
                if (accept) or_q <= in_beat;
            end
        end else if (accept) begin
            sk_valid <= 1'b1;
            sk_q     <= in_beat;
        end
    end

    assign imm_valid_o = or_valid;
    assign imm_ext_o   = or_q.imm;
    assign imm_type_o  = or_q.typ;
    assign target_o    = or_q.target;
    assign instr_o     = or_q.instr;
    assign pc_o        = or_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one 32-bit instance for the pipeline behaviour and two
// 64-bit instances (Zicsr on / off) for wide sign extension and zimm decode.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic [31:0] out_target;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        w_valid;
    logic [31:0] w_instr;
    logic [63:0] w_pc;
    logic        wa_ready_in, wa_valid, wb_ready_in, wb_valid;
    logic [63:0] wa_imm, wa_target, wa_pc, wb_imm, wb_target, wb_pc;
    logic [2:0]  wa_type, wb_type;
    logic [31:0] wa_instr, wb_instr;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .ENABLE_ZICSR(1), .ENABLE_RV64I(0)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(in_valid), .instr_ready_o(in_ready),
        .instruction_i(in_instr), .pc_i(in_pc),
        .imm_valid_o(out_valid), .imm_ready_i(out_ready),
        .imm_ext_o(out_imm), .imm_type_o(out_type), .target_o(out_target),
        .instr_o(out_instr), .pc_o(out_pc)
    );

    imm_gen_pipe #(.XLEN(64), .ENABLE_ZICSR(1), .ENABLE_RV64I(1)) dut64_a (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
        .instr_valid_i(w_valid), .instr_ready_o(wa_ready_in),
        .instruction_i(w_instr), .pc_i(w_pc),
        .imm_valid_o(wa_valid), .imm_ready_i(1'b1),
        .imm_ext_o(wa_imm), .imm_type_o(wa_type), .target_o(wa_target),
        .instr_o(wa_instr), .pc_o(wa_pc)
    );

    imm_gen_pipe #(.XLEN(64), .ENABLE_ZICSR(0), .ENABLE_RV64I(0)) dut64_b (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
        .instr_valid_i(w_valid), .instr_ready_o(wb_ready_in),
        .instruction_i(w_instr), .pc_i(w_pc),
        .imm_valid_o(wb_valid), .imm_ready_i(1'b1),
        .imm_ext_o(wb_imm), .imm_type_o(wb_type), .target_o(wb_target),
        .instr_o(wb_instr), .pc_o(wb_pc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic expect32(input string tag, input logic v, input logic [31:0] imm,
                            input logic [2:0] ty, input logic [31:0] tgt,
                            input logic [31:0] ins, input logic [31:0] pc);
        check({tag, ".valid"},  64'(out_valid),  64'(v));
        check({tag, ".imm"},    64'(out_imm),    64'(imm));
        check({tag, ".type"},   64'(out_type),   64'(ty));
        check({tag, ".target"}, 64'(out_target), 64'(tgt));
        check({tag, ".instr"},  64'(out_instr),  64'(ins));
        check({tag, ".pc"},     64'(out_pc),     64'(pc));
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    task automatic drive64(input logic v, input logic [31:0] ins, input logic [63:0] pc);
        w_valid = v;
        w_instr = ins;
        w_pc    = pc;
    endtask

    task automatic pop_order(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check(tag, 64'(out_instr), 64'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h100);
        drive64(1'b0, 32'h0, 64'h0);

        // Reset: outputs zero, inputs ignored
        @(negedge clk);
        expect32("rst_hold", 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        expect32("rst_hold2", 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        expect32("rst_release", 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
        check("rst_release.ready", 64'(in_ready), 64'd1);

        // Streaming with ready high: I, S, B back to back
        drive(1'b1, 32'hFFF00093, 32'h100);
        @(negedge clk);
        expect32("stream_i", 1'b1, 32'hFFFFFFFF, 3'd1, 32'h000000FF, 32'hFFF00093, 32'h100);
        drive(1'b1, 32'h0020A423, 32'h100);
        @(negedge clk);
        expect32("stream_s", 1'b1, 32'h8, 3'd2, 32'h108, 32'h0020A423, 32'h100);
        drive(1'b1, 32'hFE000EE3, 32'h100);
        @(negedge clk);
        expect32("stream_b", 1'b1, 32'hFFFFFFFC, 3'd3, 32'hFC, 32'hFE000EE3, 32'h100);
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("stream_drain.valid", 64'(out_valid), 64'd0);

        // Back-pressure: consumer stalls three cycles while beats are offered
        out_ready = 1'b0;
        drive(1'b1, 32'h00500113, 32'h200);
        exp_q.push_back(32'h00500113);
        @(negedge clk);
        expect32("bp_b0", 1'b1, 32'h5, 3'd1, 32'h205, 32'h00500113, 32'h200);
        check("bp_s1.ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h123452B7, 32'h204);
        exp_q.push_back(32'h123452B7);
        @(negedge clk);
        check("bp_s2.ready", 64'(in_ready), 64'd0);
        expect32("bp_hold1", 1'b1, 32'h5, 3'd1, 32'h205, 32'h00500113, 32'h200);
        drive(1'b1, 32'h008000EF, 32'h208);
        @(negedge clk);
        check("bp_s3.ready", 64'(in_ready), 64'd0);
        expect32("bp_hold2", 1'b1, 32'h5, 3'd1, 32'h205, 32'h00500113, 32'h200);
        pop_order("bp_order0");
        out_ready = 1'b1;
        @(negedge clk);
        expect32("bp_b1", 1'b1, 32'h12345000, 3'd4, 32'h12345204, 32'h123452B7, 32'h204);
        check("bp_s4.ready", 64'(in_ready), 64'd1);
        pop_order("bp_order1");
        exp_q.push_back(32'h008000EF);
        @(negedge clk);
        expect32("bp_b2", 1'b1, 32'h8, 3'd5, 32'h210, 32'h008000EF, 32'h208);
        pop_order("bp_order2");
        drive(1'b1, 32'h00112623, 32'h20C);
        exp_q.push_back(32'h00112623);
        @(negedge clk);
        expect32("bp_b3", 1'b1, 32'hC, 3'd2, 32'h218, 32'h00112623, 32'h20C);
        pop_order("bp_order3");
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("bp_drain.valid", 64'(out_valid), 64'd0);
        check("bp_drain.queue", 64'(exp_q.size()), 64'd0);

        // Flush with OR and SK full and a beat offered
        out_ready = 1'b0;
        drive(1'b1, 32'h7FF00093, 32'h400);
        @(negedge clk);
        drive(1'b1, 32'h00000517, 32'h404);
        @(negedge clk);
        check("fl_full.ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00100073, 32'h408);
        @(negedge clk);
        flush = 1'b0;
        expect32("fl_after", 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
        check("fl_after.ready", 64'(in_ready), 64'd1);

        // Flush while the input handshake fires into a stalled OR
        drive(1'b1, 32'h00A00593, 32'h40C);
        @(negedge clk);
        expect32("fl_g", 1'b1, 32'hA, 3'd1, 32'h416, 32'h00A00593, 32'h40C);
        check("fl_g.ready", 64'(in_ready), 64'd1);
        flush = 1'b1;
        drive(1'b1, 32'h01400613, 32'h410);
        @(negedge clk);
        flush = 1'b0;
        expect32("fl_hs", 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
        check("fl_hs.ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h414);
        @(negedge clk);
        expect32("fl_next", 1'b1, 32'hFFFFFFFF, 3'd1, 32'h413, 32'hFFF00093, 32'h414);
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("fl_end.valid", 64'(out_valid), 64'd0);

        // Reset mid-stream for one cycle
        drive(1'b1, 32'h00500113, 32'h500);
        @(negedge clk);
        expect32("rs_b0", 1'b1, 32'h5, 3'd1, 32'h505, 32'h00500113, 32'h500);
        rst = 1'b1;
        drive(1'b1, 32'h123452B7, 32'h504);
        @(negedge clk);
        expect32("rs_cleared", 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        drive(1'b1, 32'h008000EF, 32'h508);
        check("rs_release.ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        expect32("rs_first", 1'b1, 32'h8, 3'd5, 32'h510, 32'h008000EF, 32'h508);

        // Illegal / compressed encodings decode as none with target = pc
        drive(1'b1, 32'h00000000, 32'h300);
        @(negedge clk);
        expect32("ill_zero", 1'b1, 32'h0, 3'd0, 32'h300, 32'h00000000, 32'h300);
        drive(1'b1, 32'h0000007F, 32'h304);
        @(negedge clk);
        expect32("ill_7f", 1'b1, 32'h0, 3'd0, 32'h304, 32'h0000007F, 32'h304);
        drive(1'b1, 32'h00004501, 32'h308);
        @(negedge clk);
        expect32("ill_rvc", 1'b1, 32'h0, 3'd0, 32'h308, 32'h00004501, 32'h308);
        drive(1'b0, 32'h0, 32'h0);

        // 64-bit instances: lui, csrrwi, addiw
        drive64(1'b1, 32'h800002B7, 64'h1000);
        @(negedge clk);
        check("w_lui.valid_a", 64'(wa_valid), 64'd1);
        check("w_lui.imm_a", wa_imm, 64'hFFFFFFFF80000000);
        check("w_lui.type_a", 64'(wa_type), 64'd4);
        check("w_lui.target_a", wa_target, 64'hFFFFFFFF80001000);
        check("w_lui.imm_b", wb_imm, 64'hFFFFFFFF80000000);
        drive64(1'b1, 32'h3002D073, 64'h1000);
        @(negedge clk);
        check("w_csr.imm_a", wa_imm, 64'h5);
        check("w_csr.type_a", 64'(wa_type), 64'd6);
        check("w_csr.target_a", wa_target, 64'h1005);
        check("w_csr.imm_b", wb_imm, 64'h300);
        check("w_csr.type_b", 64'(wb_type), 64'd1);
        check("w_csr.target_b", wb_target, 64'h1300);
        drive64(1'b1, 32'hFFF0809B, 64'h2000);
        @(negedge clk);
        check("w_addiw.imm_a", wa_imm, 64'hFFFFFFFFFFFFFFFF);
        check("w_addiw.type_a", 64'(wa_type), 64'd1);
        check("w_addiw.target_a", wa_target, 64'h1FFF);
        check("w_addiw.type_b", 64'(wb_type), 64'd0);
        check("w_addiw.target_b", wb_target, 64'h2000);
        drive64(1'b0, 32'h0, 64'h0);
        @(negedge clk);
        check("w_end.valid_a", 64'(wa_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
